// File: rtl/tri_buf_pkg.sv
// Shared constants and types for the tri_buf tri-state bus block.
`timescale 1ns/1ps
package tri_buf_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage

// File: rtl/tri_buf_drv.sv
// Combinational tri-state driver: bus follows d while en=1, otherwise floats.
`timescale 1ns/1ps
module tri_buf_drv
  import tri_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  inout  wire  [WIDTH-1:0] bus
);

  // No pull or keeper: released bits are plain 'z and resolve on the net.
  assign bus = en ? d : {WIDTH{1'bz}};

endmodule

// File: rtl/tri_buf.sv
// Tri-state bus port with registered read-back sample and optional sticky
// contention flag (compiled in with TRI_BUF_CONFLICT_CHK_EN).
`timescale 1ns/1ps
module tri_buf
  import tri_buf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rw,
  input  logic [WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             conflict
);

  // Drive path is purely combinational and never sees clk, rst or state.
  tri_buf_drv #(
    .WIDTH(WIDTH)
  ) u_drv (
    .en (rw),
    .d  (data),
    .bus(bus)
  );

  // Sample stage: capture the released bus on every edge where rw=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (!rw) begin
      q       <= bus;
      q_valid <= 1'b1;
    end else begin
      q_valid <= 1'b0;
    end
  end

`ifdef TRI_BUF_CONFLICT_CHK_EN
  logic conflict_r;

  // Case inequality so unknown read-back bits also flag contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_r <= 1'b0;
    end else if (rw && (bus !== data)) begin
      conflict_r <= 1'b1;
    end
  end

  assign conflict = conflict_r;
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_tri_buf.sv
// Scoreboard bench for tri_buf: stimulus queues expectations, monitors compare.
`timescale 1ns/1ps
module tb_tri_buf;
  import tri_buf_pkg::*;

`ifdef TRI_BUF_CONFLICT_CHK_EN
  localparam logic CF_EN = 1'b1;
`else
  localparam logic CF_EN = 1'b0;
`endif

  typedef enum int {
    K_BUS_S, K_BUS_S_Z, K_BUS_D, K_BUS_D_Z, K_BUS_D_CONT,
    K_Q_S, K_QV_S, K_CF_S, K_CF0, K_CF1
  } kind_e;

  typedef struct {
    string name;
    kind_e kind;
    data_t val;
    data_t val2;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  rw_s, rw0, rw1;
  data_t data_s, d0, d1;
  logic  ext_en;
  data_t ext_val;

  wire   [7:0] bus_s;
  wire   [7:0] bus_d;
  data_t q_s, q0, q1;
  logic  qv_s, qv0, qv1;
  logic  cf_s, cf0, cf1;

  int checks = 0;
  int errors = 0;

  exp_t  gq[$];
  data_t qq[$];
  event  chk_ev;

  always #5 clk = ~clk;

  assign bus_s = ext_en ? ext_val : 8'bzzzzzzzz;

  tri_buf #(.WIDTH(8)) u_s (
    .clk(clk), .rst(rst), .rw(rw_s), .data(data_s), .bus(bus_s),
    .q(q_s), .q_valid(qv_s), .conflict(cf_s)
  );

  tri_buf #(.WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .rw(rw0), .data(d0), .bus(bus_d),
    .q(q0), .q_valid(qv0), .conflict(cf0)
  );

  tri_buf #(.WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .rw(rw1), .data(d1), .bus(bus_d),
    .q(q1), .q_valid(qv1), .conflict(cf1)
  );

  task automatic expect_val(input string n, input kind_e k, input data_t v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    e.val2 = '0;
    gq.push_back(e);
  endtask

  task automatic expect_cont(input string n, input data_t a, input data_t b);
    exp_t e;
    e.name = n;
    e.kind = K_BUS_D_CONT;
    e.val  = a;
    e.val2 = b;
    gq.push_back(e);
  endtask

  task automatic sample();
    ->chk_ev;
    #1;
  endtask

  // Combinational / register monitor: drains the expectation queue on demand.
  initial begin
    exp_t  e;
    logic  ok;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (gq.size() > 0) begin
        e   = gq.pop_front();
        ok  = 1'b0;
        act = '0;
        case (e.kind)
          K_BUS_S:      begin act = bus_s; ok = (bus_s === e.val); end
          K_BUS_S_Z:    begin act = bus_s; ok = (bus_s === 8'bzzzzzzzz); end
          K_BUS_D:      begin act = bus_d; ok = (bus_d === e.val); end
          K_BUS_D_Z:    begin act = bus_d; ok = (bus_d === 8'bzzzzzzzz); end
          K_BUS_D_CONT: begin
            act = bus_d;
            ok  = $isunknown(bus_d) || ((bus_d !== e.val) && (bus_d !== e.val2));
          end
          K_Q_S:        begin act = q_s; ok = (q_s === e.val); end
          K_QV_S:       begin act = {7'd0, qv_s}; ok = (qv_s === e.val[0]); end
          K_CF_S:       begin act = {7'd0, cf_s}; ok = (cf_s === e.val[0]); end
          K_CF0:        begin act = {7'd0, cf0};  ok = (cf0 === e.val[0]); end
          K_CF1:        begin act = {7'd0, cf1};  ok = (cf1 === e.val[0]); end
          default:      begin act = '0; ok = 1'b0; end
        endcase
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", e.name, act, e.val);
        end
      end
    end
  end

  // Read-path monitor: every q_valid pulse must match the next queued sample.
  always @(negedge clk) begin
    if (qv_s === 1'b1) begin
      checks++;
      if (qq.size() == 0) begin
        errors++;
        $display("FAIL q_sample_unexpected actual=%h required=no_sample", q_s);
      end else begin
        data_t exp_q;
        exp_q = qq.pop_front();
        if (q_s !== exp_q) begin
          errors++;
          $display("FAIL q_sample actual=%h required=%h", q_s, exp_q);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; rw_s = 1'b0; data_s = 8'd0; ext_en = 1'b0; ext_val = 8'd0;
    rw0 = 1'b0; rw1 = 1'b0; d0 = 8'd15; d1 = 8'd20;

    repeat (2) @(negedge clk);
    expect_val("rst_q", K_Q_S, 8'd0);
    expect_val("rst_qv", K_QV_S, 8'd0);
    expect_val("rst_cf", K_CF_S, 8'd0);
    expect_val("rst_cf0", K_CF0, 8'd0);
    sample();

    // Single instance, drive path only (reset held: drive must not care).
    #1; expect_val("s_released_z", K_BUS_S_Z, 8'd0); sample();
    data_s = 8'd5; rw_s = 1'b1;
    #1; expect_val("s_drive_5", K_BUS_S, 8'd5); sample();
    rw_s = 1'b0; data_s = 8'd6;
    #1; expect_val("s_release_data6_z", K_BUS_S_Z, 8'd0); sample();
    rw_s = 1'b1;
    #1; expect_val("s_drive_6", K_BUS_S, 8'd6); sample();

    // Two instances sharing bus_d.
    #1; expect_val("d_both_off_z", K_BUS_D_Z, 8'd0); sample();
    rw0 = 1'b1;
    #1; expect_val("d_u0_only_15", K_BUS_D, 8'd15); sample();
    rw0 = 1'b0; rw1 = 1'b1;
    #1; expect_val("d_u1_only_20", K_BUS_D, 8'd20); sample();
    rw0 = 1'b1;
    #1; expect_cont("d_both_contend", 8'd15, 8'd20); sample();

    @(negedge clk);
    expect_val("cf0_in_reset", K_CF0, 8'd0);
    sample();

    // Contention detection out of reset.
    rst = 1'b0;
    @(negedge clk);
    expect_val("cf0_contention", K_CF0, {7'd0, CF_EN});
    expect_val("cf1_contention", K_CF1, {7'd0, CF_EN});
    sample();
    rw1 = 1'b0;
    repeat (2) @(negedge clk);
    expect_val("d_u0_alone_15", K_BUS_D, 8'd15);
    expect_val("cf0_sticky", K_CF0, {7'd0, CF_EN});
    expect_val("cf1_sticky", K_CF1, {7'd0, CF_EN});
    sample();

    // Read path: external driver on bus_s while u_s releases.
    @(negedge clk);
    rw_s = 1'b0; ext_val = 8'hA5; ext_en = 1'b1; qq.push_back(8'hA5);
    @(negedge clk);
    rw_s = 1'b1; ext_en = 1'b0;
    @(negedge clk);
    expect_val("rd_hold_q_a5", K_Q_S, 8'hA5);
    expect_val("rd_qv_clear", K_QV_S, 8'd0);
    expect_val("rd_cf_s_clean", K_CF_S, 8'd0);
    sample();

    // Back-to-back samples.
    rw_s = 1'b0; ext_val = 8'h5A; ext_en = 1'b1; qq.push_back(8'h5A);
    @(negedge clk);
    ext_val = 8'h96; qq.push_back(8'h96);
    @(negedge clk);
    rw_s = 1'b1; ext_en = 1'b0;
    @(negedge clk);
    expect_val("rd_hold_q_96", K_Q_S, 8'h96);
    expect_val("rd_qv_clear2", K_QV_S, 8'd0);
    sample();

    // Mid-operation reset with drive enabled.
    rst = 1'b1; rw_s = 1'b1; data_s = 8'h3C;
    #1; expect_val("rst_bus_3c_pre", K_BUS_S, 8'h3C); sample();
    @(negedge clk);
    expect_val("rst2_q", K_Q_S, 8'd0);
    expect_val("rst2_qv", K_QV_S, 8'd0);
    expect_val("rst2_cf", K_CF_S, 8'd0);
    expect_val("rst2_bus_3c", K_BUS_S, 8'h3C);
    expect_val("rst2_cf0_clear", K_CF0, 8'd0);
    expect_val("rst2_cf1_clear", K_CF1, 8'd0);
    sample();
    rst = 1'b0;
    @(negedge clk);
    expect_val("post_rst_bus_3c", K_BUS_S, 8'h3C);
    expect_val("post_rst_q_held", K_Q_S, 8'd0);
    expect_val("post_rst_qv", K_QV_S, 8'd0);
    expect_val("post_rst_cf0", K_CF0, 8'd0);
    sample();

    checks++;
    if (qq.size() != 0) begin
      errors++;
      $display("FAIL q_samples_pending actual=%0d required=0", qq.size());
    end

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tri_buf.md
TRI_BUF -- requirements
Module: tri_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bus/data width in bits (legal range 1..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all registered state.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port rw  input  1  drive enable: 1 = drive bus from data, 0 = release bus (read).
REQ-005 SHALL have port data  input  WIDTH  value driven onto bus when rw=1.
REQ-006 SHALL have port bus  inout  WIDTH  shared tri-state bus, wire-resolved with other drivers.
REQ-007 SHALL have port q  output  WIDTH  registered sample of bus taken while released.
REQ-008 SHALL have port q_valid  output  1  high for one cycle after each released-bus sample.
REQ-009 SHALL have port conflict  output  1  sticky contention flag (see Configuration).

Function
REQ-010 SHALL drive bus = data on all WIDTH bits whenever rw=1, purely combinationally, zero clock latency, independent of clk and rst.
REQ-011 SHALL leave every bus bit at high impedance ('z) whenever rw=0; no weak pull, no keeper.
REQ-012 SHALL reflect data changes on bus immediately while rw=1; data changes while rw=0 SHALL have no effect on bus.
REQ-013 SHALL, with two or more instances enabled on one bus with differing data, leave resolution to the net (differing bits resolve to 'x); no arbitration inside the block.
REQ-014 SHALL, at each rising clk edge with rst=0 and rw=0, load q <= bus and set q_valid=1.
REQ-015 SHALL, at each rising clk edge with rst=0 and rw=1, hold q and clear q_valid to 0.
REQ-016 SHALL sample bus for q one cycle after a rw 1->0 transition with no extra latency (q valid on the edge where rw=0 is sampled).
REQ-017 SHALL never let registered state (q, q_valid, conflict) affect the bus drive path.

Reset
REQ-018 SHALL, at a rising clk edge with rst=1, set q=0, q_valid=0, conflict=0; rst dominates rw.
REQ-019 SHALL NOT gate the bus drive with rst; drive follows REQ-010/011 during and after reset.
REQ-020 SHALL treat reset asserted mid-operation identically: registers cleared at the next edge, bus unaffected.

Configuration
REQ-021 SHALL use macro TRI_BUF_CONFLICT_CHK_EN to compile in contention detection.
REQ-022 SHALL, with TRI_BUF_CONFLICT_CHK_EN defined, at each rising clk edge with rst=0 and rw=1, set conflict=1 if the read-back bus differs from data on any bit (unknown bits count as mismatch); conflict stays 1 until reset.
REQ-023 SHALL, without TRI_BUF_CONFLICT_CHK_EN, tie conflict to constant 0 and instantiate no comparison logic; port list unchanged.

Structure
REQ-024 SHALL place the default width constant (8) and typedef data_t (logic [WIDTH-1:0]) in shared package tri_buf_pkg.
REQ-025 SHALL implement the combinational tri-state driver as sub-module tri_buf_drv (ports en, d, bus); tri_buf adds the sample registers and conflict logic around it.

Verification
REQ-026 SHALL cover single instance: rw=0 -> bus==='z; data=5, rw=1 -> bus==5; rw=0, data=6 -> bus==='z; rw=1 -> bus==6, each checked 1 ns after stimulus, no clock.
REQ-027 SHALL cover two instances on one bus, data 15 and 20: both rw=0 -> 'z; only u0 -> 15; only u1 -> 20; both -> at least one bus bit 'x.
REQ-028 SHALL cover read path: external driver puts 8'hA5 on bus, rw=0, one clk edge -> q==8'hA5, q_valid==1; then rw=1 -> next edge q_valid==0, q holds 8'hA5.
REQ-029 SHALL cover reset: rst=1 for one edge with rw=1, data=8'h3C -> q==0, q_valid==0, conflict==0, bus==8'h3C throughout.
REQ-030 SHALL cover contention with TRI_BUF_CONFLICT_CHK_EN: two instances enabled with 15 and 20, one edge -> conflict==1 on both; release one -> conflict stays 1 until rst; without macro conflict==0.
